mem_arbiter: RTL and testbench

Sequential bus arbiter sharing the single memory slave port (internal ROM/RAM) between the instruction-fetch master (port 1) and the load/store master (port 2). Registers each granted request onto the slave bus and holds it until the slave signals ready or a timeout expires. Returns read data and a one-cycle completion pulse to the owning master, and drives a pipeline stall. It sits between the inst_fetch/mem_access stages and the memory slave, replacing the combinational mux path.

---
 rtl/mem_pkg.sv | 15 +
 rtl/arb_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and
// the grant indices used between the selector and the arbiter core.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY1 = 2'd1,
      BUSY2 = 2'd2
   } state_t;

   localparam logic [1:0] PORT_NONE = 2'd0;
   localparam logic [1:0] PORT_IF   = 2'd1;
   localparam logic [1:0] PORT_MA   = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selector: the load/store port (older instruction) wins a
// tie unless the fetch port has been starved, in which case fetch wins.
module arb_pick
   import mem_pkg::*;
(
   input  logic       i_req1,
   input  logic       i_req2,
   input  logic       i_starve,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = PORT_NONE;
      if (i_req1 && i_req2) begin
         o_grant = i_starve ? PORT_IF : PORT_MA;
      end else if (i_req1) begin
         o_grant = PORT_IF;
      end else if (i_req2) begin
         o_grant = PORT_MA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory slave port between instruction fetch (port 1) and
// load/store (port 2), one registered transfer at a time with a wait timeout.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int AW           = 64,
   parameter int DW           = 64,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 15
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          HTRANS_1,
   input  logic [AW-1:0] HADDR_1,
   input  logic          HWRITE_1,
   input  logic [DW-1:0] HWDATA_1,
   output logic          HREADY_1,
   output logic [DW-1:0] HRDATA_1,
   output logic          HRESP_1,
   input  logic          HTRANS_2,
   input  logic [AW-1:0] HADDR_2,
   input  logic          HWRITE_2,
   input  logic [DW-1:0] HWDATA_2,
   output logic          HREADY_2,
   output logic [DW-1:0] HRDATA_2,
   output logic          HRESP_2,
   output logic          PSEL,
   output logic [AW-1:0] PADDR,
   output logic          HWRITE,
   output logic [DW-1:0] PDATA,
   input  logic          PREADY,
   input  logic [DW-1:0] PRDATA,
   output logic          stall
);

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   // Abort on the last allowed wait cycle so the error pulse lands TIMEOUT+1 cycles after grant.
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   state_t          r_state, w_state_next;
   logic            r_psel, w_psel_next;
   logic [AW-1:0]   r_paddr, w_paddr_next;
   logic            r_hwrite, w_hwrite_next;
   logic [DW-1:0]   r_pdata, w_pdata_next;
   logic            r_hready1, w_hready1_next, r_hready2, w_hready2_next;
   logic            r_hresp1, w_hresp1_next, r_hresp2, w_hresp2_next;
   logic [DW-1:0]   r_hrdata1, w_hrdata1_next, r_hrdata2, w_hrdata2_next;
   logic [WW-1:0]   r_wait, w_wait_next;
   logic [SW-1:0]   r_starve, w_starve_next;
   logic [1:0]      w_grant;
   logic            w_starved, w_finish, w_err, w_capture;
   logic [DW-1:0]   w_rdata;

   assign w_starved = (r_starve == STARVE_MAX);

   arb_pick u_pick (
      .i_req1   (HTRANS_1),
      .i_req2   (HTRANS_2),
      .i_starve (w_starved),
      .o_grant  (w_grant)
   );

   always_comb begin
      w_state_next   = r_state;
      w_psel_next    = r_psel;
      w_paddr_next   = r_paddr;
      w_hwrite_next  = r_hwrite;
      w_pdata_next   = r_pdata;
      w_hready1_next = 1'b0;
      w_hready2_next = 1'b0;
      w_hresp1_next  = 1'b0;
      w_hresp2_next  = 1'b0;
      w_hrdata1_next = r_hrdata1;
      w_hrdata2_next = r_hrdata2;
      w_wait_next    = r_wait;
      w_starve_next  = r_starve;
      w_finish       = 1'b0;
      w_err          = 1'b0;
      w_capture      = 1'b0;
      w_rdata        = '0;

      case (r_state)
         IDLE: begin
            if (w_grant == PORT_IF) begin
               w_state_next  = BUSY1;
               w_psel_next   = 1'b1;
               w_paddr_next  = HADDR_1;
               w_hwrite_next = HWRITE_1;
               w_pdata_next  = HWDATA_1;
               w_wait_next   = '0;
               w_starve_next = '0;
            end else if (w_grant == PORT_MA) begin
               w_state_next  = BUSY2;
               w_psel_next   = 1'b1;
               w_paddr_next  = HADDR_2;
               w_hwrite_next = HWRITE_2;
               w_pdata_next  = HWDATA_2;
               w_wait_next   = '0;
               if (!HTRANS_1) begin
                  w_starve_next = '0;
               end else if (!w_starved) begin
                  w_starve_next = r_starve + 1'b1;
               end
            end
         end
         BUSY1, BUSY2: begin
            if (PREADY) begin
               w_finish  = 1'b1;
               w_capture = !r_hwrite;
               w_rdata   = PRDATA;
            end else if (r_wait == WAIT_LAST) begin
               w_finish  = 1'b1;
               w_err     = 1'b1;
               w_capture = 1'b1;
            end else begin
               w_wait_next = r_wait + 1'b1;
            end
            if (w_finish) begin
               w_psel_next  = 1'b0;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase

      // Route the completion to whichever master owns the transfer.
      if (w_finish && (r_state == BUSY1)) begin
         w_hready1_next = 1'b1;
         w_hresp1_next  = w_err;
         if (w_capture) w_hrdata1_next = w_rdata;
      end
      if (w_finish && (r_state == BUSY2)) begin
         w_hready2_next = 1'b1;
         w_hresp2_next  = w_err;
         if (w_capture) w_hrdata2_next = w_rdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_paddr   <= '0;
         r_hwrite  <= 1'b0;
         r_pdata   <= '0;
         r_hready1 <= 1'b0;
         r_hready2 <= 1'b0;
         r_hresp1  <= 1'b0;
         r_hresp2  <= 1'b0;
         r_hrdata1 <= '0;
         r_hrdata2 <= '0;
         r_wait    <= '0;
         r_starve  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_psel    <= w_psel_next;
         r_paddr   <= w_paddr_next;
         r_hwrite  <= w_hwrite_next;
         r_pdata   <= w_pdata_next;
         r_hready1 <= w_hready1_next;
         r_hready2 <= w_hready2_next;
         r_hresp1  <= w_hresp1_next;
         r_hresp2  <= w_hresp2_next;
         r_hrdata1 <= w_hrdata1_next;
         r_hrdata2 <= w_hrdata2_next;
         r_wait    <= w_wait_next;
         r_starve  <= w_starve_next;
      end
   end

   assign PSEL     = r_psel;
   assign PADDR    = r_paddr;
   assign HWRITE   = r_hwrite;
   assign PDATA    = r_pdata;
   assign HREADY_1 = r_hready1;
   assign HREADY_2 = r_hready2;
   assign HRESP_1  = r_hresp1;
   assign HRESP_2  = r_hresp2;
   assign HRDATA_1 = r_hrdata1;
   assign HRDATA_2 = r_hrdata2;
   assign stall    = (HTRANS_1 & ~r_hready1) | (HTRANS_2 & ~r_hready2);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by random traffic, checked against a
// transaction-level reference of the arbiter kept in the bench.
module tb_mem_arbiter;

   localparam int AW           = 64;
   localparam int DW           = 64;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 15;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          HTRANS_1, HWRITE_1, HTRANS_2, HWRITE_2;
   logic [AW-1:0] HADDR_1, HADDR_2;
   logic [DW-1:0] HWDATA_1, HWDATA_2;
   logic          HREADY_1, HRESP_1, HREADY_2, HRESP_2;
   logic [DW-1:0] HRDATA_1, HRDATA_2;
   logic          PSEL, HWRITE, PREADY, stall;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PDATA, PRDATA;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .HTRANS_1(HTRANS_1), .HADDR_1(HADDR_1), .HWRITE_1(HWRITE_1), .HWDATA_1(HWDATA_1),
      .HREADY_1(HREADY_1), .HRDATA_1(HRDATA_1), .HRESP_1(HRESP_1),
      .HTRANS_2(HTRANS_2), .HADDR_2(HADDR_2), .HWRITE_2(HWRITE_2), .HWDATA_2(HWDATA_2),
      .HREADY_2(HREADY_2), .HRDATA_2(HRDATA_2), .HRESP_2(HRESP_2),
      .PSEL(PSEL), .PADDR(PADDR), .HWRITE(HWRITE), .PDATA(PDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .stall(stall)
   );

   int checks   = 0;
   int failures = 0;

   // Reference: who owns the slave, how many busy cycles have elapsed,
   // and how many port-2 wins in a row have happened while port 1 waited.
   int          m_owner  = 0;
   int          m_age    = 0;
   int          m_streak = 0;
   logic        m_psel = 1'b0, m_pwrite = 1'b0;
   logic        m_hr1 = 1'b0, m_hr2 = 1'b0, m_rs1 = 1'b0, m_rs2 = 1'b0;
   logic [63:0] m_paddr = '0, m_pdata = '0, m_rd1 = '0, m_rd2 = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int g;
      bit err;
      m_hr1 = 1'b0; m_hr2 = 1'b0; m_rs1 = 1'b0; m_rs2 = 1'b0;
      if (!RESET) begin
         m_owner = 0; m_age = 0; m_streak = 0; m_psel = 1'b0; m_pwrite = 1'b0;
         m_paddr = '0; m_pdata = '0; m_rd1 = '0; m_rd2 = '0;
      end else if (m_owner == 0) begin
         g = 0;
         if (HTRANS_1 && HTRANS_2) g = (m_streak >= STARVE_LIMIT) ? 1 : 2;
         else if (HTRANS_1)        g = 1;
         else if (HTRANS_2)        g = 2;
         if (g == 1) begin
            m_owner = 1; m_psel = 1'b1; m_age = 0; m_streak = 0;
            m_paddr = HADDR_1; m_pwrite = HWRITE_1; m_pdata = HWDATA_1;
         end else if (g == 2) begin
            m_owner = 2; m_psel = 1'b1; m_age = 0;
            m_paddr = HADDR_2; m_pwrite = HWRITE_2; m_pdata = HWDATA_2;
            if (!HTRANS_1)                   m_streak = 0;
            else if (m_streak < STARVE_LIMIT) m_streak = m_streak + 1;
         end
      end else begin
         m_age = m_age + 1;
         if (PREADY || m_age == TIMEOUT) begin
            err = !PREADY;
            if (m_owner == 1) begin
               m_hr1 = 1'b1; m_rs1 = err;
               if (err) m_rd1 = '0; else if (!m_pwrite) m_rd1 = PRDATA;
            end else begin
               m_hr2 = 1'b1; m_rs2 = err;
               if (err) m_rd2 = '0; else if (!m_pwrite) m_rd2 = PRDATA;
            end
            m_owner = 0; m_psel = 1'b0;
         end
      end
   endtask

   // One clock: check the combinational stall, advance the reference on the
   // pre-edge inputs, then check every registered output after the edge.
   task automatic cycle();
      #1;
      chk("stall", stall, (HTRANS_1 && !m_hr1) || (HTRANS_2 && !m_hr2));
      model_step();
      @(posedge CLK);
      #1;
      chk("PSEL", PSEL, m_psel);
      chk("HREADY_1", HREADY_1, m_hr1);
      chk("HREADY_2", HREADY_2, m_hr2);
      chk("HRESP_1", HRESP_1, m_rs1);
      chk("HRESP_2", HRESP_2, m_rs2);
      chk("HRDATA_1", HRDATA_1, m_rd1);
      chk("HRDATA_2", HRDATA_2, m_rd2);
      if (m_psel) begin
         chk("PADDR", PADDR, m_paddr);
         chk("HWRITE", HWRITE, m_pwrite);
         chk("PDATA", PDATA, m_pdata);
      end
   endtask

   initial begin
      bit pend1, pend2;
      int dead;

      RESET = 1'b0; HTRANS_1 = 1'b0; HTRANS_2 = 1'b0; HWRITE_1 = 1'b0; HWRITE_2 = 1'b0;
      HADDR_1 = '0; HADDR_2 = '0; HWDATA_1 = '0; HWDATA_2 = '0; PREADY = 1'b0; PRDATA = '0;
      cycle();
      cycle();
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_hrdata1", HRDATA_1, 64'h0);
      chk("rst_paddr", PADDR, 64'h0);
      RESET = 1'b1;

      // Single fetch with zero wait states
      HTRANS_1 = 1'b1; HADDR_1 = 64'h1000; PREADY = 1'b1; PRDATA = 64'hDEADBEEF;
      cycle();
      chk("fetch_psel", PSEL, 1'b1);
      chk("fetch_paddr", PADDR, 64'h1000);
      cycle();
      chk("fetch_hready", HREADY_1, 1'b1);
      chk("fetch_hrdata", HRDATA_1, 64'hDEADBEEF);
      chk("fetch_hresp", HRESP_1, 1'b0);
      HTRANS_1 = 1'b0; PREADY = 1'b0;
      cycle();
      chk("fetch_stall_low", stall, 1'b0);

      // Both masters held: four port-2 grants, then port 1
      HTRANS_1 = 1'b1; HADDR_1 = 64'h100; HTRANS_2 = 1'b1; HADDR_2 = 64'h200;
      PREADY = 1'b1; PRDATA = 64'h1111;
      for (int c = 1; c <= 10; c++) begin
         cycle();
         if (c % 2 == 1) chk("starve_grant", PADDR, (c == 9) ? 64'h100 : 64'h200);
      end
      HTRANS_1 = 1'b0; HTRANS_2 = 1'b0;
      cycle();
      HTRANS_1 = 1'b1; HTRANS_2 = 1'b1;
      cycle();
      chk("starve_cleared", PADDR, 64'h200);
      HTRANS_1 = 1'b0;
      cycle();
      chk("starve_hready2", HREADY_2, 1'b1);
      HTRANS_2 = 1'b0;
      cycle();

      // Port-2 write with three wait states
      HTRANS_2 = 1'b1; HADDR_2 = 64'h2000; HWRITE_2 = 1'b1; HWDATA_2 = 64'h55;
      PREADY = 1'b0; PRDATA = 64'hBAD0BAD0;
      cycle();
      for (int c = 1; c <= 4; c++) begin
         chk("ws_paddr", PADDR, 64'h2000);
         chk("ws_pdata", PDATA, 64'h55);
         chk("ws_hready2_early", HREADY_2, 1'b0);
         if (c == 4) PREADY = 1'b1;
         cycle();
      end
      chk("ws_hready2", HREADY_2, 1'b1);
      chk("ws_hresp2", HRESP_2, 1'b0);
      chk("ws_hrdata2_kept", HRDATA_2, 64'h1111);
      HTRANS_2 = 1'b0; HWRITE_2 = 1'b0; PREADY = 1'b0;
      cycle();

      // Timeout on a fetch read, then a normal port-2 read
      HTRANS_1 = 1'b1; HADDR_1 = 64'h3000;
      for (int c = 1; c <= 16; c++) begin
         cycle();
         if (c < 16) chk("to_hready1_early", HREADY_1, 1'b0);
      end
      chk("to_hready1", HREADY_1, 1'b1);
      chk("to_hresp1", HRESP_1, 1'b1);
      chk("to_hrdata1", HRDATA_1, 64'h0);
      HTRANS_1 = 1'b0;
      HTRANS_2 = 1'b1; HADDR_2 = 64'h4000; PREADY = 1'b1; PRDATA = 64'hCAFE;
      cycle();
      chk("to_next_psel", PSEL, 1'b1);
      cycle();
      chk("to_next_hready2", HREADY_2, 1'b1);
      chk("to_next_hrdata2", HRDATA_2, 64'hCAFE);
      HTRANS_2 = 1'b0; PREADY = 1'b0;
      cycle();

      // Reset while port 2 is waiting on the slave
      HTRANS_2 = 1'b1; HADDR_2 = 64'h5000;
      cycle();
      cycle();
      RESET = 1'b0; HTRANS_2 = 1'b0;
      cycle();
      chk("midrst_psel", PSEL, 1'b0);
      chk("midrst_hready2", HREADY_2, 1'b0);
      chk("midrst_hrdata2", HRDATA_2, 64'h0);
      RESET = 1'b1;
      cycle();
      chk("midrst_no_pulse", HREADY_2, 1'b0);
      HTRANS_1 = 1'b1; HADDR_1 = 64'h6000; PREADY = 1'b1; PRDATA = 64'h77;
      cycle();
      cycle();
      chk("midrst_fetch_hready", HREADY_1, 1'b1);
      chk("midrst_fetch_hrdata", HRDATA_1, 64'h77);
      HTRANS_1 = 1'b0; PREADY = 1'b0;
      cycle();

      // Fetch withdrawn after grant still completes
      HTRANS_1 = 1'b1; HADDR_1 = 64'h7000;
      cycle();
      HTRANS_1 = 1'b0;
      cycle();
      chk("wd_stall", stall, 1'b0);
      PREADY = 1'b1; PRDATA = 64'h99;
      cycle();
      chk("wd_hready1", HREADY_1, 1'b1);
      chk("wd_hrdata1", HRDATA_1, 64'h99);
      chk("wd_stall_done", stall, 1'b0);
      PREADY = 1'b0;
      cycle();

      // Random traffic: masters hold requests until their completion pulse
      pend1 = 1'b0; pend2 = 1'b0; dead = 0;
      for (int n = 0; n < 800; n++) begin
         if (m_hr1) pend1 = 1'b0;
         if (m_hr2) pend2 = 1'b0;
         if (!pend1 && $urandom_range(0, 2) == 0) begin
            pend1 = 1'b1; HADDR_1 = {$urandom, $urandom};
            HWRITE_1 = 1'($urandom_range(0, 1)); HWDATA_1 = {$urandom, $urandom};
         end
         if (!pend2 && $urandom_range(0, 2) == 0) begin
            pend2 = 1'b1; HADDR_2 = {$urandom, $urandom};
            HWRITE_2 = 1'($urandom_range(0, 1)); HWDATA_2 = {$urandom, $urandom};
         end
         HTRANS_1 = pend1;
         HTRANS_2 = pend2;
         if (dead > 0) begin
            dead--;
            PREADY = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            dead = 20;
            PREADY = 1'b0;
         end else begin
            PREADY = ($urandom_range(0, 2) != 0);
         end
         PRDATA = {$urandom, $urandom};
         RESET = ($urandom_range(0, 199) != 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
